// File: rtl/ifu_pkg.sv
// Shared state encoding and default geometry for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned DEFAULT_PC_W     = 10;
  localparam int unsigned DEFAULT_RESET_PC = 0;
  localparam int unsigned JUMP_ADDR_W      = 26;
  localparam int unsigned INSTR_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/ifu_next_pc.sv
// Next fetch address: jump target when redirecting, otherwise sequential pc+1 (wraps at 2^PC_W).
module ifu_next_pc
  import ifu_pkg::*;
#(
  parameter int unsigned PC_W = DEFAULT_PC_W
) (
  input  logic [PC_W-1:0]        pc,
  input  logic                   jump_bool,
  input  logic [JUMP_ADDR_W-1:0] jump_addr,
  output logic [PC_W-1:0]        next_pc
);

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (jump_bool) begin
      next_pc = jump_addr[PC_W-1:0];
    end
  end

  // Upper target bits lie outside the instruction address space.
  generate
    if (PC_W < JUMP_ADDR_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^jump_addr[JUMP_ADDR_W-1:PC_W];
    end
  endgenerate

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/VALID/HALT sequencer feeding decode with a valid/ready handshake.
// Optional program-load write port is enabled by defining IFU_PROG_LOAD_EN.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned PC_W     = DEFAULT_PC_W,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic                   jump_bool,
  input  logic [JUMP_ADDR_W-1:0] jump_addr,
  output logic [PC_W-1:0]        instr_raddr,
  input  logic [INSTR_W-1:0]     instr_rdata,
  output logic [INSTR_W-1:0]     instruction,
  output logic [PC_W-1:0]        pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   running
`ifdef IFU_PROG_LOAD_EN
  ,
  input  logic                   load_en,
  input  logic [PC_W-1:0]        load_addr,
  input  logic [INSTR_W-1:0]     load_data,
  output logic                   imem_we,
  output logic [PC_W-1:0]        imem_waddr,
  output logic [INSTR_W-1:0]     imem_wdata
`endif
);

  localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

  ifu_state_t      state;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] next_pc;
  logic            go;

  assign go          = start && !halt_req;
  assign instr_raddr = fetch_pc;

  ifu_next_pc #(
    .PC_W (PC_W)
  ) u_next_pc (
    .pc        (pc),
    .jump_bool (jump_bool),
    .jump_addr (jump_addr),
    .next_pc   (next_pc)
  );

  // Priority in FETCH/VALID: halt, then jump, then handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      fetch_pc    <= PC_INIT;
      pc          <= PC_INIT;
      instruction <= '0;
      instr_valid <= 1'b0;
      running     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (go) begin
            state   <= ST_FETCH;
            running <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (halt_req) begin
            state   <= ST_HALT;
            running <= 1'b0;
          end else if (jump_bool) begin
            fetch_pc <= next_pc;
          end else begin
            instruction <= instr_rdata;
            pc          <= fetch_pc;
            instr_valid <= 1'b1;
            state       <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (halt_req) begin
            state       <= ST_HALT;
            instr_valid <= 1'b0;
            running     <= 1'b0;
          end else if (jump_bool || instr_ready) begin
            // next_pc resolves jump-over-handshake priority.
            fetch_pc    <= next_pc;
            instr_valid <= 1'b0;
            state       <= ST_FETCH;
          end
        end
        default: begin
          state       <= ST_IDLE;
          instr_valid <= 1'b0;
          running     <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_PROG_LOAD_EN
  logic load_ok;

  assign load_ok = load_en && ((state == ST_IDLE) || (state == ST_HALT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we    <= load_ok;
      imem_waddr <= load_addr;
      imem_wdata <= load_data;
    end
  end
`endif

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning PC/instruction-memory word-address width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset; asserted when 0.
REQ-005 SHALL have port start, input, 1, a level that begins or resumes fetching.
REQ-006 SHALL have port halt_req, input, 1, a level that stops fetching.
REQ-007 SHALL have port jump_bool, input, 1, a redirect request from the decode/ALU stage.
REQ-008 SHALL have port jump_addr, input, 26, the redirect target; bits [PC_W-1:0] are used.
REQ-009 SHALL have port instr_raddr, output, PC_W, the instruction-memory read address.
REQ-010 SHALL have port instr_rdata, input, 32, the combinational instruction-memory read data.
REQ-011 SHALL have port instruction, output, 32, the registered instruction for decode.
REQ-012 SHALL have port pc, output, PC_W, the address of the presented instruction.
REQ-013 SHALL have port instr_valid, output, 1, asserted when instruction and pc are valid.
REQ-014 SHALL have port instr_ready, input, 1, asserted when decode accepts the instruction.
REQ-015 SHALL have port running, output, 1, high in the FETCH and VALID states.

Function
REQ-016 SHALL implement the states IDLE, FETCH, VALID and HALT.
REQ-017 IDLE SHALL go to FETCH on start=1 and halt_req=0; otherwise it SHALL stay in IDLE.
REQ-018 FETCH SHALL drive instr_raddr=fetch_pc and register instruction<=instr_rdata and pc<=fetch_pc, then go to VALID; instr_valid SHALL be 1 the cycle after FETCH.
REQ-019 VALID SHALL hold instr_valid=1 with instruction and pc stable until instr_valid and instr_ready are both 1 at a rising edge.
REQ-020 On that handshake, fetch_pc SHALL become pc+1 modulo 2^PC_W (1023->0 when PC_W=10), and the state SHALL go to FETCH; throughput SHALL be 1 instruction per 2 cycles.
REQ-021 If jump_bool=1 in FETCH or VALID, then fetch_pc SHALL be set to jump_addr[PC_W-1:0], the pending instruction SHALL be squashed (instr_valid=0 next cycle), and the state SHALL go to FETCH.
REQ-022 A jump SHALL take priority over a simultaneous handshake.
REQ-023 If halt_req=1 in FETCH or VALID, the state SHALL go to HALT with instr_valid=0 next cycle; halt_req SHALL take priority over a jump and over a handshake.
REQ-024 HALT SHALL preserve fetch_pc and SHALL go to FETCH on start=1 and halt_req=0.
REQ-025 jump_bool SHALL be ignored in IDLE and HALT.
REQ-026 When the state is not FETCH, instr_raddr SHALL still equal fetch_pc.

Reset
REQ-027 While reset=0, the state SHALL be IDLE, fetch_pc=RESET_PC, pc=RESET_PC, instruction=0, instr_valid=0, running=0, instr_raddr=RESET_PC.
REQ-028 Reset asserted mid-VALID SHALL drop instr_valid immediately, without waiting for a clock edge.
REQ-029 After reset is released, the block SHALL do nothing until start=1.

Configuration
REQ-030 The macro IFU_PROG_LOAD_EN, when defined, SHALL add ports load_en(in,1), load_addr(in,PC_W), load_data(in,32), imem_we(out,1), imem_waddr(out,PC_W) and imem_wdata(out,32).
REQ-031 With IFU_PROG_LOAD_EN defined, load_en=1 SHALL be honoured only in IDLE or HALT, and imem_we SHALL be a registered copy of load_en with imem_waddr/imem_wdata following one cycle after load_en; in other states, imem_we SHALL be 0.
REQ-032 With IFU_PROG_LOAD_EN undefined, those ports SHALL be absent, and the instruction memory SHALL be read-only from this block.

Structure
REQ-033 Package ifu_pkg SHALL hold the state enum, the default PC_W and the default RESET_PC.
REQ-034 Next-PC selection (pc+1 wrap or jump target) SHALL be a combinational sub-module named ifu_next_pc.
REQ-035 The instruction memory SHALL be instantiated outside this block.

Verification
REQ-036 Reset, then start=1, memory[0]=0x20080005, instr_ready=1 -> instr_valid=1 two cycles after start is sampled, instruction=0x20080005, pc=0.
REQ-037 instr_ready=0 for 5 cycles in VALID -> instruction and pc SHALL stay unchanged and instr_valid SHALL stay 1; instr_ready=1 -> next presented pc=1.
REQ-038 pc=1023 handshaken -> next presented pc=0.
REQ-039 jump_bool=1 with jump_addr=0x2A in the same cycle as a handshake -> the next presented pc=42, and the instruction at pc+1 SHALL never be presented.
REQ-040 halt_req=1 in VALID -> HALT, instr_valid=0; start=1 -> the same pc is refetched.
REQ-041 With IFU_PROG_LOAD_EN defined: in IDLE, load 0xDEADBEEF at address 7 -> imem_we=1, imem_waddr=7, imem_wdata=0xDEADBEEF; a load attempted while running SHALL produce imem_we=0.
